agu_bank_gen: RTL and testbench

AGU_BANK_GEN -- requirements
Module: agu_bank_gen

---
 rtl/agu_bank_gen.sv | 149 ++++++++++++++
 tb/tb_agu_bank_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/agu_bank_gen.sv
// Address generation unit for a banked transform memory.
// The block walks k = 0..N-1 once per pass in natural or bit-reversed order.
// Each order index becomes a (bank, address) pair, and the bank is the
// digit-sum of the index modulo B, so B consecutive butterfly operands land
// in B different banks. It has a two-register pipeline (G -> T) with a
// valid/ready output handshake.
module agu_bank_gen #(
    parameter int N_LOG    = 10,
    parameter int BANK_LOG = 2,
    parameter int ST_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [ST_W-1:0]           num_stages,
    input  logic                      out_ready,
    output logic [N_LOG-BANK_LOG-1:0] MA_idx,
    output logic [BANK_LOG-1:0]       BN_idx,
    output logic [N_LOG-1:0]          order_out,
    output logic [ST_W-1:0]           stage_out,
    output logic                      out_valid,
    output logic                      done,
    output logic                      busy
);

    localparam int               N_DIGITS = N_LOG / BANK_LOG;
    localparam logic [N_LOG-1:0] K_LAST   = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              mode_q;
    logic [ST_W-1:0]   nst_q;
    logic [ST_W-1:0]   s_last;
    logic [N_LOG-1:0]  k;
    logic [ST_W-1:0]   s;

    logic              g_valid, g_last;
    logic [N_LOG-1:0]  g_order;
    logic [ST_W-1:0]   g_stage;
    logic              t_valid, t_last;

    logic              adv;
    logic              issue;
    logic              issue_last;
    logic              accept;

    function automatic logic [N_LOG-1:0] bitrev(input logic [N_LOG-1:0] v);
        logic [N_LOG-1:0] r;
        for (int i = 0; i < N_LOG; i++) r[i] = v[N_LOG-1-i];
        return r;
    endfunction

    function automatic logic [BANK_LOG-1:0] digit_sum(input logic [N_LOG-1:0] v);
        logic [BANK_LOG-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_DIGITS; i++) acc = acc + v[i*BANK_LOG +: BANK_LOG];
        return acc;
    endfunction

    // A pass count of zero runs a single pass.
    assign s_last = (nst_q == '0) ? '0 : nst_q - 1'b1;

    // The pipeline moves only when T is empty or T is being handed off.
    // G follows the same rule, so the whole pipe freezes on a stall.
    assign adv        = !t_valid || out_ready;
    assign issue      = (state == RUN) && adv;
    assign issue_last = issue && (k == K_LAST) && (s == s_last);
    assign accept     = t_valid && out_ready;
    assign out_valid  = t_valid;

    // Next-state and FSM outputs.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_nxt = state;
        done      = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issue_last) state_nxt = DRAIN;
            DRAIN: begin
                if (accept && t_last) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, run configuration, and the k/s index counters.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (!rst) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            nst_q  <= '0;
            k      <= '0;
            s      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                mode_q <= mode;
                nst_q  <= num_stages;
                k      <= '0;
                s      <= '0;
            end else if (issue) begin
                k <= k + 1'b1;
                if (k == K_LAST) s <= s + 1'b1;
            end
        end
    end

    // Generation register G: the order index for the current k.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_valid <= 1'b0;
            g_last  <= 1'b0;
            g_order <= '0;
            g_stage <= '0;
        end else if (adv) begin
            g_valid <= issue;
            g_last  <= issue_last;
            g_order <= mode_q ? bitrev(k) : k;
            g_stage <= s;
        end
    end

    // Translate register T: bank/address split that drives the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_valid   <= 1'b0;
            t_last    <= 1'b0;
            order_out <= '0;
            MA_idx    <= '0;
            BN_idx    <= '0;
            stage_out <= '0;
        end else if (adv) begin
            t_valid   <= g_valid;
            t_last    <= g_last;
            order_out <= g_order;
            MA_idx    <= g_order[N_LOG-1:BANK_LOG];
            BN_idx    <= digit_sum(g_order);
            stage_out <= g_stage;
        end
    end

endmodule

// File: tb/tb_agu_bank_gen.sv
// Randomized self-checking bench for agu_bank_gen with N_LOG=4, BANK_LOG=2.
// Expected transfers come from a queue that is built from the pass/index rules.
module tb_agu_bank_gen;

    localparam int N_LOG    = 4;
    localparam int BANK_LOG = 2;
    localparam int ST_W     = 4;
    localparam int N        = 16;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      start = 1'b0;
    logic                      mode = 1'b0;
    logic [ST_W-1:0]           num_stages = '0;
    logic                      out_ready = 1'b0;
    logic [N_LOG-BANK_LOG-1:0] MA_idx;
    logic [BANK_LOG-1:0]       BN_idx;
    logic [N_LOG-1:0]          order_out;
    logic [ST_W-1:0]           stage_out;
    logic                      out_valid;
    logic                      done;
    logic                      busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int order;
        int ma;
        int bn;
        int stage;
    } xfer_t;

    xfer_t exp_q[$];

    agu_bank_gen #(.N_LOG(N_LOG), .BANK_LOG(BANK_LOG), .ST_W(ST_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_stages(num_stages),
        .out_ready(out_ready), .MA_idx(MA_idx), .BN_idx(BN_idx), .order_out(order_out),
        .stage_out(stage_out), .out_valid(out_valid), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rev4(input int v);
        return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ma"}, int'(MA_idx), 0);
        check({tag, "_bn"}, int'(BN_idx), 0);
        check({tag, "_order"}, int'(order_out), 0);
        check({tag, "_stage"}, int'(stage_out), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // One run. On entry and on exit the time is 1 unit after a rising edge.
    task automatic do_run(input logic m, input int ns, input int stall_pct, input bit stall5,
                          input bit poke, input bit at_done, input int abort_at);
        int    eff;
        int    cyc;
        int    nx;
        int    done_cyc;
        bit    done_seen;
        bit    aborted;
        bit    prev_stall;
        int    h_order, h_ma, h_bn, h_stage;
        int    bn_mask;
        xfer_t e;

        eff = (ns == 0) ? 1 : ns;
        exp_q.delete();
        for (int sp = 0; sp < eff; sp++)
            for (int kk = 0; kk < N; kk++) begin
                e.order = m ? rev4(kk) : kk;
                e.ma    = e.order / 4;
                e.bn    = ((e.order % 4) + (e.order / 4)) % 4;
                e.stage = sp;
                exp_q.push_back(e);
            end

        mode       = m;
        num_stages = ST_W'(ns);
        out_ready  = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        cyc = 0; nx = 0; done_cyc = -1; done_seen = 0; aborted = 0;
        prev_stall = 0; bn_mask = 0;
        h_order = 0; h_ma = 0; h_bn = 0; h_stage = 0;
        while (!done_seen && !aborted && cyc < 3000) begin
            if (cyc < 3) out_ready = 1'b1;
            else if (stall5) out_ready = !(cyc >= 10 && cyc < 15);
            else if (stall_pct > 0) out_ready = ($urandom_range(99) >= stall_pct);
            else out_ready = 1'b1;
            if (poke) begin
                start      = ($urandom_range(2) == 0);
                mode       = 1'($urandom);
                num_stages = ST_W'($urandom);
            end
            #1;
            check("busy_in_run", int'(busy), 1);
            if (cyc < 2) check("latency_not_yet", int'(out_valid), 0);
            if (cyc == 2) check("latency_first", int'(out_valid), 1);
            if (stall_pct == 0 && !stall5 && cyc >= 2) check("no_bubble", int'(out_valid), 1);
            if (prev_stall) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_order", int'(order_out), h_order);
                check("stall_ma", int'(MA_idx), h_ma);
                check("stall_bn", int'(BN_idx), h_bn);
                check("stall_stage", int'(stage_out), h_stage);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_xfer", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("order", int'(order_out), e.order);
                    check("ma", int'(MA_idx), e.ma);
                    check("bn", int'(BN_idx), e.bn);
                    check("stage", int'(stage_out), e.stage);
                    check("done_flag", int'(done), (exp_q.size() == 0) ? 1 : 0);
                    if (m) begin
                        bn_mask = bn_mask | (1 << BN_idx);
                        if ((nx % 4) == 3) begin
                            check("bn_distinct", bn_mask, 15);
                            bn_mask = 0;
                        end
                    end
                end
                nx++;
                if (done) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                    if (at_done) start = 1'b1;
                end
                if (abort_at >= 0 && nx == abort_at) begin
                    #2 rst = 1'b0;
                    #1 check_all_zero("abort_async");
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    check_all_zero("abort_hold");
                    start = 1'b0;
                    rst   = 1'b1;
                    aborted = 1;
                end
            end else begin
                check("done_no_xfer", int'(done), 0);
            end
            prev_stall = out_valid && !out_ready;
            h_order = int'(order_out); h_ma = int'(MA_idx);
            h_bn = int'(BN_idx); h_stage = int'(stage_out);
            if (!aborted) begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        start     = 1'b0;
        out_ready = 1'b1;
        if (aborted) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check_all_zero("after_abort");
            end
        end else begin
            check("done_seen", int'(done_seen), 1);
            check("xfer_count", nx, eff * N);
            check("queue_empty", exp_q.size(), 0);
            if (stall_pct == 0) check("done_cycle", done_cyc, eff * N + 1 + (stall5 ? 5 : 0));
            #1;
            check("busy_fall", int'(busy), 0);
            check("idle_valid", int'(out_valid), 0);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check("stay_idle_busy", int'(busy), 0);
                check("stay_idle_valid", int'(out_valid), 0);
                check("stay_idle_done", int'(done), 0);
            end
        end
    endtask

    initial begin
        // Reset state, with start driven to show it is ignored while in reset.
        start = 1'b1;
        mode = 1'b1;
        num_stages = 4'd3;
        out_ready = 1'b1;
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_clocked");
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset_idle");

        do_run(1'b0, 1, 0, 1'b0, 1'b0, 1'b0, -1);
        do_run(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, -1);
        do_run(1'b0, 3, 0, 1'b0, 1'b0, 1'b1, -1);
        do_run(1'b0, 1, 0, 1'b1, 1'b0, 1'b0, -1);
        do_run(1'b1, 2, 0, 1'b0, 1'b1, 1'b1, -1);
        do_run(1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 7);
        do_run(1'b0, 1, 0, 1'b0, 1'b0, 1'b0, -1);
        do_run(1'($urandom), 0, 0, 1'b0, 1'b0, 1'b0, -1);
        for (int r = 0; r < 6; r++)
            do_run(1'($urandom), int'($urandom_range(4, 1)), 30, 1'b0, (r % 2) == 1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
